// File: rtl/rs232in_fifo_pkg.sv
// Shared definitions for the rs232 receive path: default FIFO depth, register offsets, FIFO op encoding.
// No logic; latency and backpressure do not apply.
// Imported by rs232in_fifo, its interface and its storage.
package rs232in_fifo_pkg;

    localparam int RS232IN_FIFO_DEPTH_LOG2 = 4;

    // rs232 peripheral register offsets from FF00_0000
    localparam logic [1:0] RS232_OUT_DATA = 2'd0;
    localparam logic [1:0] RS232_IN_DATA  = 2'd1;
    localparam logic [1:0] RS232_IN_COUNT = 2'd2;
    localparam logic [1:0] RS232_TSC      = 2'd3;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/rs232in_fifo_if.sv
// Bundle between rs232in/rs232 (master) and the receive FIFO (slave).
// Wires only; overrun_cnt exists only when RS232IN_FIFO_STATS_EN is defined.
// No backpressure toward rs232in: a full FIFO drops and flags overrun.
interface rs232in_fifo_if
    import rs232in_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = RS232IN_FIFO_DEPTH_LOG2
);
    logic                  in_attention;
    logic [7:0]            in_data;
    logic                  rd;
    logic                  clr_overrun;
    logic [7:0]            rd_data;
    logic [DEPTH_LOG2:0]   count;
    logic                  empty;
    logic                  full;
    logic                  overrun;
`ifdef RS232IN_FIFO_STATS_EN
    logic [7:0]            overrun_cnt;
`endif

    modport master (
        output in_attention, in_data, rd, clr_overrun,
        input  rd_data, count, empty, full, overrun
`ifdef RS232IN_FIFO_STATS_EN
        , overrun_cnt
`endif
    );

    modport slave (
        input  in_attention, in_data, rd, clr_overrun,
        output rd_data, count, empty, full, overrun
`ifdef RS232IN_FIFO_STATS_EN
        , overrun_cnt
`endif
    );

endinterface

// File: rtl/rs232in_fifo_mem.sv
// Byte storage for the receive FIFO: 8 x 2^ADDR_W, synchronous write, asynchronous read.
// Write lands at the clock edge; read is combinational from raddr.
// No flow control; the caller guarantees we only when a slot is free.
module rs232in_fifo_mem #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    // No reset so the array maps onto distributed RAM
    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rs232in_fifo.sv
// Receive byte FIFO between rs232in and the rs232 register block; first-word-fall-through head.
// Push/pop at edge N visible at N+1; all outputs come from registered state only.
// Full FIFO drops incoming bytes and sets sticky overrun; RS232IN_FIFO_STATS_EN adds overrun_cnt.
module rs232in_fifo
    import rs232in_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = RS232IN_FIFO_DEPTH_LOG2
) (
    input  logic            clk,
    input  logic            reset_n,
    rs232in_fifo_if.slave   bus
);

    localparam logic [DEPTH_LOG2:0] CAPACITY = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic                  overrun_q;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [7:0]            head;
    fifo_op_e              op;

    assign empty = (count_q == '0);
    assign full  = (count_q == CAPACITY);

    // A pop in the same cycle frees the slot a full FIFO needs
    assign pop  = bus.rd && !empty;
    assign push = bus.in_attention && (!full || bus.rd);
    assign drop = bus.in_attention && full && !bus.rd;
    assign op   = fifo_op(push, pop);

    always_comb begin
        count_nxt = count_q;
        case (op)
            FIFO_PUSH: count_nxt = count_q + 1'b1;
            FIFO_POP:  count_nxt = count_q - 1'b1;
            default:   count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_nxt;
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    rs232in_fifo_mem #(
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign bus.rd_data = empty ? 8'h00 : head;
    assign bus.count   = count_q;
    assign bus.empty   = empty;
    assign bus.full    = full;
    assign bus.overrun = overrun_q;

`ifdef RS232IN_FIFO_STATS_EN
    logic [7:0] overrun_cnt_q;

    // Clear takes priority over a same-cycle drop; the flag above still sets
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overrun_cnt_q <= 8'h00;
        end else if (bus.clr_overrun) begin
            overrun_cnt_q <= 8'h00;
        end else if (drop && (overrun_cnt_q != 8'hFF)) begin
            overrun_cnt_q <= overrun_cnt_q + 8'h01;
        end
    end

    assign bus.overrun_cnt = overrun_cnt_q;
`endif

endmodule

// File: tb/tb_rs232in_fifo.sv
module tb_rs232in_fifo;
    import rs232in_fifo_pkg::*;

    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic clk;
    logic reset_n;
    int   n_total;
    int   n_pass;

    rs232in_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

    rs232in_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: a byte queue plus the overrun flag and counter rules
    logic [7:0] mq[$];
    bit         m_ovr;
    int         m_cnt;
    bit         m_live;

    always @(posedge clk) begin
        if (!reset_n) begin
            mq.delete();
            m_ovr  = 1'b0;
            m_cnt  = 0;
            m_live = 1'b1;
        end else begin
            bit pop_ok;
            bit drop;
            pop_ok = (bus.rd === 1'b1) && (mq.size() != 0);
            drop   = (bus.in_attention === 1'b1) && (mq.size() == DEPTH) && !pop_ok;
            if (pop_ok) void'(mq.pop_front());
            if ((bus.in_attention === 1'b1) && !drop) mq.push_back(bus.in_data);
            if (drop) m_ovr = 1'b1;
            else if (bus.clr_overrun === 1'b1) m_ovr = 1'b0;
            if (bus.clr_overrun === 1'b1) m_cnt = 0;
            else if (drop && m_cnt < 255) m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("m_count",   32'(bus.count),   32'(mq.size()));
            check("m_empty",   32'(bus.empty),   32'(mq.size() == 0));
            check("m_full",    32'(bus.full),    32'(mq.size() == DEPTH));
            check("m_overrun", 32'(bus.overrun), 32'(m_ovr));
            check("m_rd_data", 32'(bus.rd_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
`ifdef RS232IN_FIFO_STATS_EN
            check("m_ovr_cnt", 32'(bus.overrun_cnt), 32'(m_cnt));
`endif
        end
    end

    task automatic step(input logic att, input logic [7:0] d, input logic r, input logic c);
        @(negedge clk);
        bus.in_attention = att;
        bus.in_data      = d;
        bus.rd           = r;
        bus.clr_overrun  = c;
        @(posedge clk);
        #1;
        bus.in_attention = 1'b0;
        bus.in_data      = 8'h00;
        bus.rd           = 1'b0;
        bus.clr_overrun  = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        m_live  = 1'b0;
        reset_n = 1'b0;
        bus.in_attention = 1'b0;
        bus.in_data      = 8'h00;
        bus.rd           = 1'b0;
        bus.clr_overrun  = 1'b0;

        // 1. reset
        repeat (2) @(posedge clk);
        settle();
        check("rst_count",   32'(bus.count),   32'h0);
        check("rst_empty",   32'(bus.empty),   32'h1);
        check("rst_full",    32'(bus.full),    32'h0);
        check("rst_overrun", 32'(bus.overrun), 32'h0);
        check("rst_rd_data", 32'(bus.rd_data), 32'h0);
`ifdef RS232IN_FIFO_STATS_EN
        check("rst_ovr_cnt", 32'(bus.overrun_cnt), 32'h0);
`endif
        reset_n = 1'b1;

        // 2. two pushes then one pop
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        settle();
        check("t2_count",   32'(bus.count),   32'h2);
        check("t2_head",    32'(bus.rd_data), 32'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        settle();
        check("t2_head2",   32'(bus.rd_data), 32'h3C);
        check("t2_count2",  32'(bus.count),   32'h1);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // 3. 17 pushes into an empty FIFO, 17th dropped
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'(i + 1), 1'b0, 1'b0);
        settle();
        check("t3_full",    32'(bus.full),    32'h1);
        check("t3_count",   32'(bus.count),   32'h10);
        check("t3_overrun", 32'(bus.overrun), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            settle();
            check("t3_order", 32'(bus.rd_data), 32'(i + 1));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        settle();
        check("t3_empty",   32'(bus.empty),   32'h1);
        check("t3_rd_zero", 32'(bus.rd_data), 32'h0);

        // 4. push+pop while full
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        settle();
        check("t4_count",   32'(bus.count),   32'h10);
        check("t4_overrun", 32'(bus.overrun), 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            settle();
            if (i == 0)         check("t4_first", 32'(bus.rd_data), 32'h11);
            if (i == DEPTH - 1) check("t4_last",  32'(bus.rd_data), 32'h77);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // 5. rd on empty, then push+rd on empty
        step(1'b0, 8'h00, 1'b1, 1'b0);
        settle();
        check("t5_count0",  32'(bus.count),   32'h0);
        check("t5_empty",   32'(bus.empty),   32'h1);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        settle();
        check("t5_count1",  32'(bus.count),   32'h1);
        check("t5_head",    32'(bus.rd_data), 32'h5A);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // 6. overrun set/clear priority
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        settle();
        check("t6_set",     32'(bus.overrun), 32'h1);
        step(1'b1, 8'hEF, 1'b0, 1'b1);
        settle();
        check("t6_set_wins", 32'(bus.overrun), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        settle();
        check("t6_clr",     32'(bus.overrun), 32'h0);
        check("t6_intact",  32'(bus.rd_data), 32'hC0);
`ifdef RS232IN_FIFO_STATS_EN
        for (int i = 0; i < 300; i++) step(1'b1, 8'hFF, 1'b0, 1'b0);
        settle();
        check("t6_cnt_sat", 32'(bus.overrun_cnt), 32'hFF);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        settle();
        check("t6_cnt_clr", 32'(bus.overrun_cnt), 32'h0);
`endif

        // reset mid-burst discards contents
        step(1'b1, 8'h99, 1'b1, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        settle();
        reset_n = 1'b1;
        check("rst2_empty", 32'(bus.empty),   32'h1);
        check("rst2_ovr",   32'(bus.overrun), 32'h0);
        step(1'b1, 8'h42, 1'b0, 1'b0);
        settle();
        check("rst2_head",  32'(bus.rd_data), 32'h42);

        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
